// File: rtl/prio_req_arbiter_if.sv
// Handshake bundle between the request/grant stage and its consumer.
// The slave modport is the arbiter's view; master is the driving/consuming side.
interface prio_req_arbiter_if #(
  parameter int N   = 3,
  parameter int OCW = 8,
  parameter int CW  = $clog2(N + 1)
);
  logic [N-1:0]   req_i;
  logic           flush_i;
  logic [CW-1:0]  code_o;
  logic           code_valid_o;
  logic           code_ready_i;
  logic [N-1:0]   pend_o;
  logic [OCW-1:0] drop_cnt_o;

  modport slave (
    input  req_i,
    input  flush_i,
    input  code_ready_i,
    output code_o,
    output code_valid_o,
    output pend_o,
    output drop_cnt_o
  );

  modport master (
    output req_i,
    output flush_i,
    output code_ready_i,
    input  code_o,
    input  code_valid_o,
    input  pend_o,
    input  drop_cnt_o
  );
endinterface

// File: rtl/prio_req_arbiter.sv
// Sticky request collector with highest-index priority grant.
// Request pulses accumulate in a pending vector; the highest pending bit is
// offered as code k+1 over a valid/ready handshake. Grants are never preempted,
// and back-to-back grants issue without a bubble. Re-requests of a bit that is
// already pending (and not being cleared this cycle) are counted as drops.
// The interface instance must be built with the same N and OCW as this module.
module prio_req_arbiter #(
  parameter int N   = 3,
  parameter int OCW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  prio_req_arbiter_if.slave   bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q;
  logic [N-1:0]   pend_q;
  logic [CW-1:0]  code_q;
  logic           valid_q;
  logic [OCW-1:0] drop_q;

  logic           fire;
  logic [N-1:0]   clr;
  logic [N-1:0]   pend_next;
  logic [CW-1:0]  sel;
  logic [N-1:0]   drops;
  logic [CW-1:0]  drop_pop;
  logic [OCW:0]   drop_sum;
  logic [OCW-1:0] drop_next;

  assign fire = valid_q & bus.code_ready_i;

  // Decode the granted code back to the one-hot bit retired by this handshake.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
    clr = '0;
    for (int k = 0; k < N; k++) begin
      clr[k] = fire && (code_q == CW'(k + 1));
    end
  end

  // A fresh request on the bit being retired re-arms it: new request wins.
  assign pend_next = (pend_q & ~clr) | bus.req_i;

  // Highest set bit of the next pending vector wins; later iterations override.
  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++) begin
      if (pend_next[k]) sel = CW'(k + 1);
    end
  end

  // Count re-requests that merged into a bit already pending and not retiring.
  assign drops = bus.req_i & pend_q & ~clr;

  // Population count of merged requests, then a saturating add.
  always_comb begin
    drop_pop = '0;
    for (int k = 0; k < N; k++) begin
      drop_pop = drop_pop + CW'(drops[k]);
    end
    drop_sum  = {1'b0, drop_q} + (OCW + 1)'(drop_pop);
    drop_next = drop_sum[OCW] ? {OCW{1'b1}} : drop_sum[OCW-1:0];
  end

  // Grant FSM with registered code/valid; flush wins over any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every state register here is a small flop, so all of them are cleared by the async reset.
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else if (bus.flush_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      pend_q <= pend_next;
      drop_q <= drop_next;
      unique case (state_q)
        IDLE: begin
          if (pend_next != '0) begin
            code_q  <= sel;
            valid_q <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (fire) begin
            if (pend_next != '0) begin
              code_q <= sel;
            end else begin
              code_q  <= '0;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          code_q  <= '0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.code_o       = code_q;
  assign bus.code_valid_o = valid_q;
  assign bus.pend_o       = pend_q;
  assign bus.drop_cnt_o   = drop_q;

  // A valid grant always carries a nonzero code, and code is zero when idle.
  a_code_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    valid_q |-> (code_q != '0));
  a_code_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !valid_q |-> (code_q == '0));
  // A stalled grant holds its code unless a flush intervenes.
  a_no_preempt: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_q && !bus.code_ready_i && !bus.flush_i) |=> (valid_q && $stable(code_q)));

endmodule

// File: tb/tb_prio_req_arbiter.sv
// Directed bench for prio_req_arbiter. Stimulus pushes expected grant codes
// into a scoreboard queue; a monitor pops and compares on every accepted grant.
// Register state (pend, valid, drop count) is checked directly after edges.
module tb_prio_req_arbiter;

  localparam int N   = 3;
  localparam int OCW = 8;

  logic clk;
  logic rst_n;

  prio_req_arbiter_if #(.N(N), .OCW(OCW)) bus ();

  prio_req_arbiter #(.N(N), .OCW(OCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs may be changed right after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input int c, input int p);
    check({tag, "_valid"}, 32'(bus.code_valid_o), 32'(v));
    check({tag, "_code"},  32'(bus.code_o), 32'(c));
    check({tag, "_pend"},  32'(bus.pend_o), 32'(p));
  endtask

  // Scoreboard monitor: a grant is consumed when valid&ready and no flush.
  always @(negedge clk) begin
    if (rst_n && bus.code_valid_o && bus.code_ready_i && !bus.flush_i) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_grant", 32'(bus.code_o), 32'd0);
      end else begin
        check("sb_grant_code", 32'(bus.code_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    bus.req_i        = '0;
    bus.flush_i      = 1'b0;
    bus.code_ready_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // 1: reset state, then idle with no requests
    chk_state("rst", 1'b0, 0, 0);
    check("rst_drop", 32'(bus.drop_cnt_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_state("idle", 1'b0, 0, 0);
    end

    // 2: 101 pulse with ready held -> 3, then 1, then idle
    bus.code_ready_i = 1'b1;
    exp_q.push_back(3);
    exp_q.push_back(1);
    bus.req_i = 3'b101;
    tick();
    bus.req_i = 3'b000;
    chk_state("t2_a", 1'b1, 3, 3'b101);
    tick();
    chk_state("t2_b", 1'b1, 1, 3'b001);
    tick();
    chk_state("t2_c", 1'b0, 0, 3'b000);

    // 3: no preemption while stalled, then back-to-back grants
    bus.code_ready_i = 1'b0;
    bus.req_i = 3'b001;
    tick();
    bus.req_i = 3'b000;
    chk_state("t3_a", 1'b1, 1, 3'b001);
    tick();
    bus.req_i = 3'b100;
    tick();
    bus.req_i = 3'b000;
    chk_state("t3_b", 1'b1, 1, 3'b101);
    tick();
    chk_state("t3_c", 1'b1, 1, 3'b101);
    exp_q.push_back(1);
    exp_q.push_back(3);
    bus.code_ready_i = 1'b1;
    tick();
    chk_state("t3_d", 1'b1, 3, 3'b100);
    tick();
    chk_state("t3_e", 1'b0, 0, 3'b000);

    // 4: re-requests on a pending, stalled bit count as drops
    bus.code_ready_i = 1'b0;
    bus.req_i = 3'b001;
    tick();
    check("t4_drop0", 32'(bus.drop_cnt_o), 32'd0);
    tick();
    check("t4_drop1", 32'(bus.drop_cnt_o), 32'd1);
    tick();
    bus.req_i = 3'b000;
    check("t4_drop2", 32'(bus.drop_cnt_o), 32'd2);
    chk_state("t4_a", 1'b1, 1, 3'b001);
    exp_q.push_back(1);
    bus.code_ready_i = 1'b1;
    tick();
    chk_state("t4_b", 1'b0, 0, 3'b000);

    // 5: same-cycle re-request on the firing bit keeps it pending, no drop
    bus.code_ready_i = 1'b0;
    bus.req_i = 3'b010;
    tick();
    chk_state("t5_a", 1'b1, 2, 3'b010);
    exp_q.push_back(2);
    exp_q.push_back(2);
    bus.code_ready_i = 1'b1;
    tick();
    bus.req_i = 3'b000;
    chk_state("t5_b", 1'b1, 2, 3'b010);
    check("t5_drop", 32'(bus.drop_cnt_o), 32'd2);
    tick();
    chk_state("t5_c", 1'b0, 0, 3'b000);

    // 6: flush beats fire, discards same-cycle req, keeps drop count
    bus.code_ready_i = 1'b0;
    bus.req_i = 3'b110;
    tick();
    chk_state("t6_a", 1'b1, 3, 3'b110);
    bus.flush_i      = 1'b1;
    bus.req_i        = 3'b001;
    bus.code_ready_i = 1'b1;
    tick();
    bus.flush_i      = 1'b0;
    bus.req_i        = 3'b000;
    bus.code_ready_i = 1'b0;
    chk_state("t6_b", 1'b0, 0, 3'b000);
    check("t6_drop", 32'(bus.drop_cnt_o), 32'd2);
    tick();
    chk_state("t6_c", 1'b0, 0, 3'b000);

    // Multi-drop popcount and saturation of the drop counter
    bus.req_i = 3'b111;
    tick();
    chk_state("sat_a", 1'b1, 3, 3'b111);
    check("sat_drop_a", 32'(bus.drop_cnt_o), 32'd2);
    tick();
    check("sat_drop_pop3", 32'(bus.drop_cnt_o), 32'd5);
    for (int i = 0; i < 90; i++) tick();
    check("sat_drop_max", 32'(bus.drop_cnt_o), 32'd255);
    bus.req_i = 3'b000;
    exp_q.push_back(3);
    exp_q.push_back(2);
    exp_q.push_back(1);
    bus.code_ready_i = 1'b1;
    tick();
    chk_state("sat_b", 1'b1, 2, 3'b011);
    tick();
    tick();
    chk_state("sat_c", 1'b0, 0, 3'b000);
    check("sat_drop_hold", 32'(bus.drop_cnt_o), 32'd255);

    // 7: async reset mid-grant clears everything before the next edge
    bus.code_ready_i = 1'b0;
    bus.req_i = 3'b100;
    tick();
    bus.req_i = 3'b000;
    chk_state("t7_a", 1'b1, 3, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("t7_b", 1'b0, 0, 3'b000);
    check("t7_drop", 32'(bus.drop_cnt_o), 32'd0);
    rst_n = 1'b1;
    bus.code_ready_i = 1'b1;
    tick();
    tick();
    chk_state("t7_c", 1'b0, 0, 3'b000);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
